// File: rtl/video_console_pkg.sv
// Shared types and constants for the text-console sequencer.
// Build option: define VIDEO_CONSOLE_SCROLL_EN to scroll on row overflow;
// otherwise overflow wraps to row 0 and blanks that row.
package video_console_pkg;
   localparam int DEF_COLS = 80;
   localparam int DEF_ROWS = 60;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_CURSOR = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_BS = 8'h08;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PUT    = 3'd1,
`ifdef VIDEO_CONSOLE_SCROLL_EN
      ST_SCR_RD = 3'd2,
      ST_SCR_WR = 3'd3,
`endif
      ST_FILL   = 3'd4,
      ST_CLR    = 3'd5
   } state_e;

   // Cursor update requests issued by the top-level FSM.
   typedef enum logic [2:0] {
      CUR_NONE, CUR_PUT, CUR_LF, CUR_CR, CUR_BS, CUR_SET, CUR_HOME
   } cur_op_e;
endpackage

// File: rtl/video_console_cursor.sv
// Hardware cursor: row/col registers, character advance, CR/LF/BS, clamped
// load and home. Flags the operation that runs the row past the last line.
// Build option: VIDEO_CONSOLE_SCROLL_EN keeps the row on the last line at
// overflow (scroll); without it the row wraps to 0.
module video_console_cursor
   import video_console_pkg::*;
#(
   parameter int COLS = DEF_COLS,
   parameter int ROWS = DEF_ROWS
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  cur_op_e    op_i,
   input  logic [5:0] set_row_i,
   input  logic [6:0] set_col_i,
   output logic [5:0] row_o,
   output logic [6:0] col_o,
   output logic       ovf_o
);
   localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);
   localparam logic [6:0] COL_LAST = 7'(COLS - 1);
`ifdef VIDEO_CONSOLE_SCROLL_EN
   localparam logic [5:0] ROW_OVF = ROW_LAST;
`else
   localparam logic [5:0] ROW_OVF = 6'd0;
`endif

   logic [5:0] row_q, row_d;
   logic [6:0] col_q, col_d;
   logic       nl;

   // Next cursor position and overflow flag for the requested operation.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      ovf_o = 1'b0;
      nl    = (op_i == CUR_LF) || (op_i == CUR_PUT && col_q == COL_LAST);
      case (op_i)
         CUR_PUT:        col_d = (col_q == COL_LAST) ? 7'd0 : col_q + 7'd1;
         CUR_LF, CUR_CR: col_d = 7'd0;
         CUR_BS:         if (col_q != 7'd0) col_d = col_q - 7'd1;
         CUR_SET: begin
            row_d = (set_row_i > ROW_LAST) ? ROW_LAST : set_row_i;
            col_d = (set_col_i > COL_LAST) ? COL_LAST : set_col_i;
         end
         CUR_HOME: begin
            row_d = 6'd0;
            col_d = 7'd0;
         end
         default: ;
      endcase
      if (nl) begin
         if (row_q == ROW_LAST) begin
            ovf_o = 1'b1;
            row_d = ROW_OVF;
         end else begin
            row_d = row_q + 6'd1;
         end
      end
   end

   // Cursor registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         row_q <= 6'd0;
         col_q <= 7'd0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row_o = row_q;
   assign col_o = col_q;
endmodule

// File: rtl/video_console.sv
// Text-console sequencer: Wishbone-style register port, cursor, and the
// screen-RAM write sequencer (cell put, scroll/wrap-fill, clear).
// Build option: VIDEO_CONSOLE_SCROLL_EN enables the copy-up scroll.
module video_console
   import video_console_pkg::*;
#(
   parameter int         COLS      = DEF_COLS,
   parameter int         ROWS      = DEF_ROWS,
   parameter logic [7:0] FILL_CHAR = 8'h00
) (
   input  logic        clk_25mhz,
   input  logic        rst,
   input  logic [3:0]  adr_i,
   input  logic [31:0] dat_i,
   input  logic [3:0]  sel_i,
   input  logic        we_i,
   input  logic        stb_i,
   output logic        ack_o,
   output logic [31:0] dat_o,
   output logic [12:0] vram_adr_o,
   output logic [7:0]  vram_dat_o,
   output logic        vram_we_o,
   input  logic [7:0]  vram_dat_i
);
   localparam logic [12:0] COLS13     = 13'(COLS);
   localparam logic [12:0] CELLS_LAST = 13'(COLS * ROWS - 1);
`ifdef VIDEO_CONSOLE_SCROLL_EN
   localparam state_e      OVF_ST     = ST_SCR_RD;
   localparam logic [12:0] OVF_CNT    = COLS13;
   localparam logic [12:0] FILL_FIRST = 13'(COLS * (ROWS - 1));
   localparam logic [12:0] FILL_LAST  = CELLS_LAST;
`else
   localparam state_e      OVF_ST     = ST_FILL;
   localparam logic [12:0] OVF_CNT    = 13'd0;
   localparam logic [12:0] FILL_LAST  = 13'(COLS - 1);
`endif

   state_e      state_q, state_d;
   logic [12:0] cnt_q, cnt_d;
   logic [12:0] put_adr_q, put_adr_d;
   logic [7:0]  put_dat_q, put_dat_d;
   logic        ovf_q, ovf_d;
   cur_op_e     cur_op;
   logic [5:0]  cur_row;
   logic [6:0]  cur_col;
   logic        cur_ovf;
   logic [12:0] cur_adr;
   logic        busy, rd, wr;
   logic [7:0]  ch;
   logic        unused_ok;

   assign busy    = state_q != ST_IDLE;
   assign rd      = stb_i & ~we_i;
   // A stalled write is simply not acked; the master holds it until IDLE.
   assign ack_o   = rd | (stb_i & we_i & ~busy);
   assign wr      = stb_i & we_i & ~busy & sel_i[0];
   assign ch      = dat_i[7:0];
   assign cur_adr = {7'd0, cur_row} * COLS13 + {6'd0, cur_col};
`ifdef VIDEO_CONSOLE_SCROLL_EN
   assign unused_ok = ^{dat_i[31:14], sel_i[3:1], adr_i[1:0]};
`else
   assign unused_ok = ^{dat_i[31:14], sel_i[3:1], adr_i[1:0], vram_dat_i};
`endif

   video_console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
      .clk_i     (clk_25mhz),
      .rst_i     (rst),
      .op_i      (cur_op),
      .set_row_i (dat_i[13:8]),
      .set_col_i (dat_i[6:0]),
      .row_o     (cur_row),
      .col_o     (cur_col),
      .ovf_o     (cur_ovf)
   );

   // Register read mux; zero whenever no read is being acked.
   always_comb begin
      dat_o = '0;
      if (rd) begin
         case (adr_i[3:2])
            REG_CURSOR: dat_o = {18'd0, cur_row, 1'b0, cur_col};
            REG_STATUS: dat_o = {31'd0, busy};
            default: ;
         endcase
      end
   end

   // Cursor request: bus writes in IDLE, home at the end of a clear.
   always_comb begin
      cur_op = CUR_NONE;
      if (state_q == ST_IDLE && wr) begin
         if (adr_i[3:2] == REG_DATA) begin
            case (ch)
               CH_LF:   cur_op = CUR_LF;
               CH_CR:   cur_op = CUR_CR;
               CH_BS:   cur_op = CUR_BS;
               default: cur_op = CUR_PUT;
            endcase
         end else if (adr_i[3:2] == REG_CURSOR) begin
            cur_op = CUR_SET;
         end
      end else if (state_q == ST_CLR && cnt_q == CELLS_LAST) begin
         cur_op = CUR_HOME;
      end
   end

   // Sequencer next state and the screen-RAM port.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      put_adr_d  = put_adr_q;
      put_dat_d  = put_dat_q;
      ovf_d      = ovf_q;
      vram_adr_o = '0;
      vram_dat_o = '0;
      vram_we_o  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cur_op == CUR_PUT) begin
               put_adr_d = cur_adr;
               put_dat_d = ch;
               ovf_d     = cur_ovf;
               state_d   = ST_PUT;
            end else if (cur_op == CUR_LF && cur_ovf) begin
               state_d = OVF_ST;
               cnt_d   = OVF_CNT;
            end else if (wr && adr_i[3:2] == REG_CTRL && dat_i[0]) begin
               state_d = ST_CLR;
               cnt_d   = '0;
            end
         end
         ST_PUT: begin
            vram_adr_o = put_adr_q;
            vram_dat_o = put_dat_q;
            vram_we_o  = 1'b1;
            state_d    = ovf_q ? OVF_ST : ST_IDLE;
            cnt_d      = OVF_CNT;
         end
`ifdef VIDEO_CONSOLE_SCROLL_EN
         ST_SCR_RD: begin
            vram_adr_o = cnt_q;
            state_d    = ST_SCR_WR;
         end
         ST_SCR_WR: begin
            vram_adr_o = cnt_q - COLS13;
            vram_dat_o = vram_dat_i;
            vram_we_o  = 1'b1;
            if (cnt_q == CELLS_LAST) begin
               state_d = ST_FILL;
               cnt_d   = FILL_FIRST;
            end else begin
               state_d = ST_SCR_RD;
               cnt_d   = cnt_q + 13'd1;
            end
         end
`endif
         ST_FILL: begin
            vram_adr_o = cnt_q;
            vram_dat_o = FILL_CHAR;
            vram_we_o  = 1'b1;
            if (cnt_q == FILL_LAST) state_d = ST_IDLE;
            else                    cnt_d   = cnt_q + 13'd1;
         end
         ST_CLR: begin
            vram_adr_o = cnt_q;
            vram_dat_o = FILL_CHAR;
            vram_we_o  = 1'b1;
            if (cnt_q == CELLS_LAST) state_d = ST_IDLE;
            else                     cnt_d   = cnt_q + 13'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer state; reset aborts any sequence in progress.
   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         put_adr_q <= '0;
         put_dat_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         put_adr_q <= put_adr_d;
         put_dat_q <= put_dat_d;
         ovf_q     <= ovf_d;
      end
   end
endmodule

// File: tb/tb_video_console.sv
// Randomized bench for video_console with a behavioural screen/cursor model.
// Follows VIDEO_CONSOLE_SCROLL_EN the same way the design does.
module tb_video_console;
   localparam int C = 80, R = 60, CELLS = C * R;

   logic        clk_25mhz = 1'b0, rst = 1'b1;
   logic [3:0]  adr_i = '0, sel_i = '0;
   logic [31:0] dat_i = '0, dat_o;
   logic        we_i = 1'b0, stb_i = 1'b0, ack_o;
   logic [12:0] vram_adr_o;
   logic [7:0]  vram_dat_o, rd_q = '0;
   logic        vram_we_o;

   int          vectors = 0, miscompares = 0;
   logic [7:0]  vram [CELLS];   // the screen RAM the DUT drives
   logic [7:0]  mram [CELLS];   // model image
   int          exp_q [$];      // expected writes, adr*256+dat, in order
   int          mrow = 0, mcol = 0;

   always #20 clk_25mhz = ~clk_25mhz;

   video_console dut (
      .clk_25mhz(clk_25mhz), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
      .we_i(we_i), .stb_i(stb_i), .ack_o(ack_o), .dat_o(dat_o), .vram_adr_o(vram_adr_o),
      .vram_dat_o(vram_dat_o), .vram_we_o(vram_we_o), .vram_dat_i(rd_q));

   task automatic chk(input string nm, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s: no response within bound", nm);
   endtask

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 7 + (i >> 5));
   endfunction

   // ---- behavioural model ----
   task automatic put(input int a, input logic [7:0] v);
      mram[a] = v;
      exp_q.push_back(a * 256 + int'(v));
   endtask

   task automatic mdl_nl(inout int busy);
      if (mrow < R - 1) mrow++;
      else begin
`ifdef VIDEO_CONSOLE_SCROLL_EN
         for (int a = C; a < CELLS; a++) put(a - C, mram[a]);
         for (int a = CELLS - C; a < CELLS; a++) put(a, 8'h00);
         busy += 2 * (CELLS - C) + C;
`else
         mrow = 0;
         for (int a = 0; a < C; a++) put(a, 8'h00);
         busy += C;
`endif
      end
   endtask

   task automatic mdl_write(input logic [1:0] r, input logic [31:0] d, output int busy);
      logic [7:0] c;
      busy = 0;
      c = d[7:0];
      case (r)
         2'd0: begin
            if (c == 8'h0A) begin mcol = 0; mdl_nl(busy); end
            else if (c == 8'h0D) mcol = 0;
            else if (c == 8'h08) begin if (mcol > 0) mcol--; end
            else begin
               put(mrow * C + mcol, c);
               busy = 1;
               if (mcol == C - 1) begin mcol = 0; mdl_nl(busy); end
               else mcol++;
            end
         end
         2'd1: begin
            mrow = (int'(d[13:8]) > R - 1) ? R - 1 : int'(d[13:8]);
            mcol = (int'(d[6:0]) > C - 1) ? C - 1 : int'(d[6:0]);
         end
         2'd3: if (d[0]) begin
            for (int a = 0; a < CELLS; a++) put(a, 8'h00);
            mrow = 0; mcol = 0; busy = CELLS;
         end
         default: ;
      endcase
   endtask

   // ---- bus tasks: all start and end 1 time unit after a rising edge ----
   task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s,
                            output int stall);
      adr_i = {r, 2'b00}; dat_i = d; sel_i = s; we_i = 1'b1; stb_i = 1'b1; stall = 0;
      @(negedge clk_25mhz);
      while (!ack_o && stall < 20000) begin stall++; @(negedge clk_25mhz); end
      if (!ack_o) timeout("write_ack");
      @(posedge clk_25mhz); #1;
      stb_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
      adr_i = {r, 2'b00}; we_i = 1'b0; stb_i = 1'b1;
      @(negedge clk_25mhz);
      chk("read_ack", ack_o, 1);
      d = dat_o;
      @(posedge clk_25mhz); #1;
      stb_i = 1'b0;
   endtask

   task automatic measure_busy(output int n);
      adr_i = 4'h8; we_i = 1'b0; stb_i = 1'b1; n = 0;
      @(negedge clk_25mhz);
      while (dat_o[0] && n < 20000) begin n++; @(negedge clk_25mhz); end
      if (n >= 20000) timeout("busy_end");
      @(posedge clk_25mhz); #1;
      stb_i = 1'b0;
   endtask

   task automatic do_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s,
                           output int busy, output int stall);
      int mb;
      mb = 0;
      bus_write(r, d, s, stall);
      if (s[0]) mdl_write(r, d, mb);
      measure_busy(busy);
      chk("busy_cycles", busy, mb);
      chk("writes_drained", exp_q.size(), 0);
   endtask

   task automatic image_check(input string nm);
      int bad;
      bad = 0;
      for (int i = 0; i < CELLS; i++) if (vram[i] !== mram[i]) bad++;
      chk(nm, bad, 0);
   endtask

   initial begin
      int b, s, budget;
      logic [31:0] d;
      for (int i = 0; i < CELLS; i++) begin vram[i] = 8'h00; mram[i] = 8'h00; end
      repeat (3) @(posedge clk_25mhz);
      #1 rst = 1'b0;

      // RAM emulation plus per-cycle output check against the model's write list.
      fork
         forever begin
            int e, got;
            @(negedge clk_25mhz);
            chk("adr_range", int'(vram_adr_o < 13'(CELLS)), 1);
            if (vram_we_o) begin
               got = int'(vram_adr_o) * 256 + int'(vram_dat_o);
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL vram_write: unexpected adr=%0d dat=0x%0h", vram_adr_o, vram_dat_o);
               end else begin
                  e = exp_q.pop_front();
                  if (got != e) begin
                     miscompares++;
                     $display("FAIL vram_write: got adr=%0d dat=0x%0h, want adr=%0d dat=0x%0h",
                              got / 256, got % 256, e / 256, e % 256);
                  end
               end
               if (vram_adr_o < 13'(CELLS)) vram[vram_adr_o] = vram_dat_o;
            end
            rd_q = (vram_adr_o < 13'(CELLS)) ? vram[vram_adr_o] : 8'h00;
         end
      join_none

      // reset state
      @(negedge clk_25mhz);
      chk("rst_we", vram_we_o, 0);
      chk("rst_adr", vram_adr_o, 0);
      chk("rst_vdat", vram_dat_o, 0);
      chk("rst_dat_o_idle", dat_o, 0);
      @(posedge clk_25mhz); #1;
      bus_read(2'd2, d); chk("rst_status", d, 0);
      bus_read(2'd1, d); chk("rst_cursor", d, 0);

      // single put, then wrap at the last column
      do_write(2'd0, 32'h41, 4'hF, b, s);
      chk("put_busy", b, 1);
      bus_read(2'd1, d); chk("cursor_after_put", d, 32'h0001);
      chk("ram0_A", vram[0], 8'h41);
      do_write(2'd1, 32'h004F, 4'hF, b, s);
      do_write(2'd0, 32'h42, 4'hF, b, s);
      bus_read(2'd1, d); chk("cursor_col_wrap", d, 32'h0100);
      chk("ram79_B", vram[79], 8'h42);
      do_write(2'd1, 32'h3F7F, 4'hF, b, s);
      bus_read(2'd1, d); chk("cursor_clamp", d, 32'h3B4F);
      do_write(2'd1, 32'h0500, 4'hF, b, s);
      do_write(2'd0, 32'h08, 4'hF, b, s);
      bus_read(2'd1, d); chk("bs_at_col0", d, 32'h0500);
      chk("bs_no_busy", b, 0);

      // row overflow from an LF on the last row
      for (int i = 0; i < CELLS; i++) begin vram[i] = pat(i); mram[i] = pat(i); end
      do_write(2'd1, 32'h3B05, 4'hF, b, s);
      do_write(2'd0, 32'h0A, 4'hF, b, s);
      bus_read(2'd1, d);
`ifdef VIDEO_CONSOLE_SCROLL_EN
      chk("scroll_busy", b, 9520);
      chk("scroll_cursor", d, 32'h3B00);
      chk("scroll_ram0", vram[0], pat(80));
      chk("scroll_ram4719", vram[4719], pat(4799));
      chk("scroll_ram4720", vram[4720], 8'h00);
      chk("scroll_ram4799", vram[4799], 8'h00);
`else
      chk("wrap_busy", b, 80);
      chk("wrap_cursor", d, 32'h0000);
      chk("wrap_ram0", vram[0], 8'h00);
      chk("wrap_ram79", vram[79], 8'h00);
      chk("wrap_ram80", vram[80], pat(80));
`endif
      image_check("image_after_overflow");

      // clear
      do_write(2'd3, 32'h1, 4'hF, b, s);
      chk("clear_busy", b, 4800);
      bus_read(2'd1, d); chk("clear_cursor", d, 0);
      bus_read(2'd2, d); chk("clear_status", d, 0);
      chk("clear_ram4799", vram[4799], 8'h00);
      image_check("image_after_clear");

      // a DATA write during a clear stalls until IDLE, then lands at 0
      do_write(2'd1, 32'h0A0A, 4'hF, b, s);
      bus_write(2'd3, 32'h1, 4'hF, s);
      mdl_write(2'd3, 32'h1, b);
      do_write(2'd0, 32'h55, 4'hF, b, s);
      chk("stall_cycles", s, 4800);
      chk("stall_ram0", vram[0], 8'h55);

      // sel_i[0]=0: acked, no effect
      do_write(2'd0, 32'h77, 4'hE, b, s);
      bus_read(2'd1, d); chk("sel0_cursor", d, 32'h0001);
      chk("sel0_ram1", vram[1], 8'h00);

      // randomized traffic
      budget = 2;
      for (int k = 0; k < 300; k++) begin
         int kind, pick;
         logic [7:0] c;
         bit would;
         kind = $urandom_range(0, 9);
         if (kind < 5) begin
            pick = $urandom_range(0, 6);
            case (pick)
               4: c = 8'h0A;
               5: c = 8'h0D;
               6: c = 8'h08;
               default: begin
                  c = 8'($urandom_range(0, 255));
                  if (c == 8'h0A || c == 8'h0D || c == 8'h08) c = 8'h2A;
               end
            endcase
            would = (mrow == R - 1) &&
                    (c == 8'h0A || (c != 8'h0D && c != 8'h08 && mcol == C - 1));
            if (would) begin
               if (budget == 0) c = 8'h0D;
               else budget--;
            end
            do_write(2'd0, {24'($urandom), c}, 4'hF, b, s);
         end else if (kind < 7) begin
            do_write(2'd1, $urandom, 4'hF, b, s);
         end else if (kind == 7) begin
            do_write(2'($urandom_range(0, 3)), $urandom, 4'($urandom) & 4'hE, b, s);
         end else begin
            bus_read(2'd1, d); chk("rand_cursor", d, (mrow << 8) | mcol);
            bus_read(2'd0, d); chk("data_reads_zero", d, 0);
         end
      end
      image_check("image_after_random");

      // reset in the middle of an overflow sequence
      do_write(2'd1, 32'h3B00, 4'hF, b, s);
      bus_write(2'd0, 32'h0A, 4'hF, s);
      mdl_write(2'd0, 32'h0A, b);
      repeat (40) @(posedge clk_25mhz);
      #1 rst = 1'b1;
      @(posedge clk_25mhz); #1 rst = 1'b0;
      @(negedge clk_25mhz);
      chk("abort_we", vram_we_o, 0);
      exp_q.delete();
      for (int i = 0; i < CELLS; i++) mram[i] = vram[i];
      mrow = 0; mcol = 0;
      @(posedge clk_25mhz); #1;
      bus_read(2'd2, d); chk("abort_status", d, 0);
      bus_read(2'd1, d); chk("abort_cursor", d, 0);
      do_write(2'd0, 32'h5A, 4'hF, b, s);
      chk("abort_put_ram0", vram[0], 8'h5A);
      image_check("image_final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/video_console.md
# video_console

Text-console sequencer in front of the 80x60 character screen RAM. It accepts characters and commands from the CPU over a Wishbone-style slave port and keeps a hardware cursor. It turns each character into video-RAM write sequences: single-cell writes, line wrap, full-screen scroll and screen clear. It is the only writer of the screen RAM's write port; the display scan-out side is unchanged.

## Interface
Parameters:
- COLS, 80, characters per row
- ROWS, 60, character rows
- FILL_CHAR, 8'h00, code written by clear and scroll-fill

Ports:
- clk_25mhz  in  1  pixel/system clock
- rst  in  1  synchronous, active-high reset
- adr_i  in  4  byte address; adr_i[3:2] selects the register
- dat_i  in  32  write data
- sel_i  in  4  byte lanes; a write needs sel_i[0]
- we_i  in  1  write enable
- stb_i  in  1  strobe
- ack_o  out  1  acknowledge (combinational)
- dat_o  out  32  read data, valid while ack_o
- vram_adr_o  out  13  screen RAM address, row*COLS+col
- vram_dat_o  out  8  screen RAM write data
- vram_we_o  out  1  screen RAM write strobe
- vram_dat_i  in  8  screen RAM read data, 1-cycle latency after vram_adr_o

## Operation
- Registers:
  - 0 DATA: write puts a character; reads as 0.
  - 1 CURSOR: row in [13:8], col in [6:0]. A write clamps col to COLS-1 and row to ROWS-1.
  - 2 STATUS: bit0 = busy.
  - 3 CTRL: writing bit0=1 clears the screen and homes the cursor.
- Character handling:
  - 0x0A: col=0, row+1.
  - 0x0D: col=0.
  - 0x08: col-1 if col>0, with no RAM write.
  - Any other code: written at the cursor, then col+1. At col=COLS-1 the cursor wraps to col=0, row+1.
- Row advance past ROWS-1 triggers a scroll.
  - Copy addresses COLS..COLS*ROWS-1 to addr-COLS.
  - Fill the last row with FILL_CHAR.
  - Row stays at ROWS-1.
- State machine:
  - IDLE: accept writes. DATA printable → PUT. DATA advance with row overflow → SCR_RD. CTRL clear → CLR.
  - PUT: one RAM write. Then SCR_RD if the write caused row overflow, else IDLE.
  - SCR_RD: drive the source address → SCR_WR.
  - SCR_WR: write vram_dat_i to source-COLS. → SCR_RD, or FILL when the source was the last cell.
  - FILL: COLS writes of the last row → IDLE.
  - CLR: COLS*ROWS writes from address 0 → IDLE, cursor (0,0).
- busy = state != IDLE.
- Bus rules:
  - Reads always ack immediately.
  - Writes to any register while busy are stalled: ack_o=0 until IDLE, and no side effect.
  - A write with sel_i[0]=0 is acked and ignored.
- Counters: one 13-bit address counter for scroll and clear; row is 6 bits and col is 7 bits, with no wider arithmetic.

## Timing
- Reset values: state IDLE, cursor (0,0), vram_we_o=0, vram_adr_o=0, vram_dat_o=0, busy=0. dat_o is 0 when not acked.
- Reset mid-sequence aborts immediately. RAM contents stay partially updated, and the cursor returns to (0,0).
- Printable char: write accepted in cycle N; vram_we_o is high in N+1; busy is 0 again in N+2.
- Control chars 0x0A/0x0D/0x08 without overflow: cursor updates in N+1, with no busy cycle.
- Scroll (default size): 2 cycles per copied cell × 4720, plus 80 fill cycles = 9520 busy cycles.
- Clear: 4800 busy cycles.
- vram_we_o is high for exactly one cycle per cell write. vram_adr_o is always < COLS*ROWS.

## Configuration
- VIDEO_CONSOLE_SCROLL_EN defined: row overflow scrolls as described above.
- Not defined:
  - Row overflow wraps the row to 0 and clears row 0 with FILL_CHAR (80 busy cycles) instead of copying.
  - SCR_RD/SCR_WR are absent.

## Structure
- Package video_console_pkg holds:
  - The state enum.
  - Register offsets REG_DATA/REG_CURSOR/REG_STATUS/REG_CTRL.
  - Control codes CH_LF/CH_CR/CH_BS.
  - Default COLS/ROWS.
- One sub-module, video_console_cursor, holds the cursor registers. It handles advance/CR/LF/BS/clamp and flags row overflow. The top level keeps the bus decode, the FSM and the RAM port.

## Test plan
- Reset, then write DATA=0x41 → one vram write adr=0 dat=0x41; CURSOR reads 0x0001.
- CURSOR=(row 0, col 79), write 0x42 → write at adr 79; CURSOR reads (1,0).
- Fill RAM with address-pattern, CURSOR=(59,5), write 0x0A → 9520 busy cycles. Afterwards RAM[0]=old RAM[80], RAM[4719]=old RAM[4799], RAM[4720..4799]=0x00, CURSOR=(59,0).
- CTRL=1 → 4800 writes of 0x00 covering adr 0..4799, then cursor (0,0) and STATUS=0.
- While a clear is busy, issue a DATA write → ack_o held low until IDLE; the char is then written at adr 0.
- Assert rst mid-scroll → next cycle vram_we_o=0, STATUS=0, CURSOR=0. Without VIDEO_CONSOLE_SCROLL_EN, an LF at row 59 → row 0 cleared, cursor (0,0).
